edge_pulse_stretcher: RTL and testbench

Multi-channel edge detector. Each channel detects a programmable edge type on a level input that is synchronous to `clock`, and turns it into a pulse. The pulse is asserted combinationally in the edge cycle and then held, retriggerable, for a programmable total length. Each channel also records the edge in a sticky event flag that software clears. Used wherever status levels need to become one-shot or minimum-width events, such as link-up/down, port-enable changes and interrupt sources in the switch control plane.

---
 rtl/edge_pulse_stretcher.sv | 112 +++++++++++
 tb/tb_edge_pulse_stretcher.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_stretcher.sv
// Multi-channel edge detector: each channel turns a selected edge into a retriggerable pulse and a sticky event flag.
// Optional 2-flop input synchronizer is enabled by defining EDGE_PULSE_SYNC_STAGES_EN.
module edge_pulse_stretcher #(
  parameter int   WIDTH        = 8,
  parameter int   PULSE_LENGTH = 1,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     level_in,
  input  logic [2*WIDTH-1:0]   edge_mode,
  input  logic [WIDTH-1:0]     event_clear,
  output logic [WIDTH-1:0]     pulse_out,
  output logic [WIDTH-1:0]     event_pending,
  output logic                 any_event
);

  localparam int CW = (PULSE_LENGTH > 1) ? $clog2(PULSE_LENGTH) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_LENGTH - 1);

  logic [WIDTH-1:0]         level_s;
  logic [WIDTH-1:0]         d_q;
  logic [WIDTH-1:0]         rise;
  logic [WIDTH-1:0]         fall;
  logic [WIDTH-1:0]         hit;
  logic [WIDTH-1:0]         mode_on;
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d;
  logic [WIDTH-1:0]         pend_q;
  logic [WIDTH-1:0]         pend_d;

`ifdef EDGE_PULSE_SYNC_STAGES_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= {WIDTH{RESET_LEVEL}};
      sync2_q <= {WIDTH{RESET_LEVEL}};
    end else begin
      sync1_q <= level_in;
      sync2_q <= sync1_q;
    end
  end

  assign level_s = sync2_q;
`else
  assign level_s = level_in;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_q <= {WIDTH{RESET_LEVEL}};
    end else begin
      d_q <= level_s;
    end
  end

  // Edge qualification; mode 00 disables the channel entirely.
  always_comb begin
    rise    = level_s & ~d_q;
    fall    = ~level_s & d_q;
    hit     = '0;
    mode_on = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mode_on[i] = |edge_mode[2*i +: 2];
      case (edge_mode[2*i +: 2])
        2'b01:   hit[i] = rise[i];
        2'b10:   hit[i] = fall[i];
        2'b11:   hit[i] = rise[i] | fall[i];
        default: hit[i] = 1'b0;
      endcase
    end
  end

  // Counter holds the remaining pulse cycles after the current one; a hit reloads rather than accumulates.
  always_comb begin
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pulse_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!mode_on[i]) begin
        cnt_d[i] = '0;
      end else if (hit[i]) begin
        cnt_d[i] = RELOAD;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      pulse_out[i] = (hit[i] | (cnt_q[i] != '0)) & mode_on[i];
      // A new hit in the same cycle as a clear keeps the flag set.
      if (hit[i]) begin
        pend_d[i] = 1'b1;
      end else if (event_clear[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign event_pending = pend_q;
  assign any_event     = |pend_q;

endmodule

// File: tb/tb_edge_pulse_stretcher.sv
// Directed bench for edge_pulse_stretcher: table of vectors on a PULSE_LENGTH=4 instance,
// plus hand sequences on PULSE_LENGTH=1 and PULSE_LENGTH=8 instances and reset corner cases.
module tb_edge_pulse_stretcher;

  logic clk;
  logic rst;

  // PULSE_LENGTH=4 instance
  logic [3:0] l4, c4, p4, e4;
  logic [7:0] m4;
  logic       a4;
  // PULSE_LENGTH=1 instance
  logic [3:0] l1, c1, p1, e1;
  logic [7:0] m1;
  logic       a1;
  // PULSE_LENGTH=8 instance
  logic [3:0] l8, c8, p8, e8;
  logic [7:0] m8;
  logic       a8;

  int n_checks;
  int n_err;

  typedef struct {
    logic [3:0] level;
    logic [7:0] mode;
    logic [3:0] clear;
    logic [3:0] pulse;
    logic [3:0] pend;
    logic       any;
  } vec_t;

  vec_t vq[$];

  edge_pulse_stretcher #(.WIDTH(4), .PULSE_LENGTH(4), .RESET_LEVEL(1'b0)) u_pl4 (
    .clock(clk), .reset(rst), .level_in(l4), .edge_mode(m4), .event_clear(c4),
    .pulse_out(p4), .event_pending(e4), .any_event(a4)
  );

  edge_pulse_stretcher #(.WIDTH(4), .PULSE_LENGTH(1), .RESET_LEVEL(1'b0)) u_pl1 (
    .clock(clk), .reset(rst), .level_in(l1), .edge_mode(m1), .event_clear(c1),
    .pulse_out(p1), .event_pending(e1), .any_event(a1)
  );

  edge_pulse_stretcher #(.WIDTH(4), .PULSE_LENGTH(8), .RESET_LEVEL(1'b0)) u_pl8 (
    .clock(clk), .reset(rst), .level_in(l8), .edge_mode(m8), .event_clear(c8),
    .pulse_out(p8), .event_pending(e8), .any_event(a8)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] lv, input logic [7:0] md, input logic [3:0] cl,
                         input logic [3:0] pu, input logic [3:0] pe, input logic an);
    vec_t v;
    v.level = lv; v.mode = md; v.clear = cl;
    v.pulse = pu; v.pend = pe; v.any = an;
    vq.push_back(v);
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 2 time units later.
  task automatic drive4(input logic [3:0] lv, input logic [7:0] md, input logic [3:0] cl);
    @(negedge clk);
    l4 = lv; m4 = md; c4 = cl;
    #2;
  endtask

  localparam logic [7:0] M  = 8'h79;  // ch0 rise, ch1 fall, ch2 any, ch3 rise
  localparam logic [7:0] M0 = 8'h78;  // same with ch0 off

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    l4 = '0; m4 = '0; c4 = '0;
    l1 = '0; m1 = '0; c1 = '0;
    l8 = '0; m8 = '0; c8 = '0;

    //            level    mode cl       pulse    pend     any
    add_vec(4'b0000, M,  4'b0000, 4'b0000, 4'b0000, 1'b0);
    add_vec(4'b0001, M,  4'b0000, 4'b0001, 4'b0000, 1'b0);
    add_vec(4'b0001, M,  4'b0000, 4'b0001, 4'b0001, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0001, 4'b0001, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0001, 4'b0001, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0000, 4'b0001, 1'b1);
    add_vec(4'b0011, M,  4'b0000, 4'b0000, 4'b0001, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0010, 4'b0001, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0010, 4'b0011, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0010, 4'b0011, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0010, 4'b0011, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0000, 4'b0011, 1'b1);
    add_vec(4'b0101, M,  4'b0000, 4'b0100, 4'b0011, 1'b1);
    add_vec(4'b0101, M,  4'b0000, 4'b0100, 4'b0111, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0100, 4'b0111, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0100, 4'b0111, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0100, 4'b0111, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0100, 4'b0111, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0000, 4'b0111, 1'b1);
    add_vec(4'b0001, M,  4'b0111, 4'b0000, 4'b0111, 1'b1);
    add_vec(4'b0001, M,  4'b0000, 4'b0000, 4'b0000, 1'b0);
    add_vec(4'b1001, M,  4'b0000, 4'b1000, 4'b0000, 1'b0);
    add_vec(4'b0001, M,  4'b0000, 4'b1000, 4'b1000, 1'b1);
    add_vec(4'b1001, M,  4'b1000, 4'b1000, 4'b1000, 1'b1);
    add_vec(4'b1001, M,  4'b1000, 4'b1000, 4'b1000, 1'b1);
    add_vec(4'b1001, M,  4'b0000, 4'b1000, 4'b0000, 1'b0);
    add_vec(4'b1001, M,  4'b0000, 4'b1000, 4'b0000, 1'b0);
    add_vec(4'b1001, M,  4'b0001, 4'b0000, 4'b0000, 1'b0);
    add_vec(4'b1001, M,  4'b0000, 4'b0000, 4'b0000, 1'b0);
    add_vec(4'b1000, M,  4'b0000, 4'b0000, 4'b0000, 1'b0);
    add_vec(4'b1001, M,  4'b0000, 4'b0001, 4'b0000, 1'b0);
    add_vec(4'b1001, M0, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    add_vec(4'b1001, M,  4'b0000, 4'b0000, 4'b0001, 1'b1);
    add_vec(4'b1000, M0, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    add_vec(4'b1000, M,  4'b0000, 4'b0000, 4'b0001, 1'b1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset_pend", 32'(e4), 32'h0);
    chk("reset_any", 32'(a4), 32'h0);
    chk("reset_pulse", 32'(p4), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors on the PULSE_LENGTH=4 instance
    for (int i = 0; i < vq.size(); i++) begin
      drive4(vq[i].level, vq[i].mode, vq[i].clear);
      chk($sformatf("row%0d_pulse", i), 32'(p4), 32'(vq[i].pulse));
      chk($sformatf("row%0d_pend", i),  32'(e4), 32'(vq[i].pend));
      chk($sformatf("row%0d_any", i),   32'(a4), 32'(vq[i].any));
    end

    // PULSE_LENGTH=1: plain one-cycle edge pulse
    @(negedge clk); m1 = 8'h01; l1 = 4'b0000; #2;
    chk("pl1_idle_pulse", 32'(p1), 32'h0);
    @(negedge clk); l1 = 4'b0001; #2;
    chk("pl1_edge_pulse", 32'(p1), 32'h1);
    chk("pl1_edge_pend", 32'(e1), 32'h0);
    @(negedge clk); #2;
    chk("pl1_after_pulse", 32'(p1), 32'h0);
    chk("pl1_after_pend", 32'(e1), 32'h1);
    chk("pl1_after_any", 32'(a1), 32'h1);
    @(negedge clk); #2;
    chk("pl1_later_pulse", 32'(p1), 32'h0);

    // PULSE_LENGTH=8: channel disabled in pulse cycle 3
    @(negedge clk); m8 = 8'h01; l8 = 4'b0000; #2;
    chk("pl8_idle_pulse", 32'(p8), 32'h0);
    @(negedge clk); l8 = 4'b0001; #2;
    chk("pl8_cyc1_pulse", 32'(p8), 32'h1);
    @(negedge clk); #2;
    chk("pl8_cyc2_pulse", 32'(p8), 32'h1);
    chk("pl8_cyc2_pend", 32'(e8), 32'h1);
    @(negedge clk); m8 = 8'h00; #2;
    chk("pl8_off_pulse", 32'(p8), 32'h0);
    @(negedge clk); m8 = 8'h01; #2;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pl8_post%0d_pulse", k), 32'(p8), 32'h0);
      chk($sformatf("pl8_post%0d_pend", k), 32'(e8), 32'h1);
      @(negedge clk); #2;
    end

    // Level held through reset produces an edge on the first cycle after release
    @(negedge clk);
    l4 = 4'b0101; m4 = 8'h55; c4 = 4'b0000; rst = 1'b1;
    #2;
    chk("rst_hold_pend", 32'(e4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rel_first_pulse", 32'(p4), 32'h5);
    chk("rel_first_pend", 32'(e4), 32'h0);
    @(negedge clk); l4 = 4'b0000; #2;
    chk("rel_second_pulse", 32'(p4), 32'h5);
    chk("rel_second_pend", 32'(e4), 32'h5);
    chk("rel_second_any", 32'(a4), 32'h1);
    // Asynchronous reset mid-pulse
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pulse", 32'(p4), 32'h0);
    chk("async_rst_pend", 32'(e4), 32'h0);
    chk("async_rst_any", 32'(a4), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #2;
    chk("post_rst_pulse", 32'(p4), 32'h0);
    chk("post_rst_pend", 32'(e4), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
